// File: rtl/scpu_bus_ctrl_if.sv
// Z80 sub-CPU bus bundle: core pins, board decode inputs and interrupt/NMI sources.
// The controller takes the slave side; the CPU core and board decode take the master side.
interface scpu_bus_ctrl_if #(
    parameter int IRQ_N = 4
);
    logic             cen;
    logic [IRQ_N-1:0] irq_src;
    logic [IRQ_N-1:0] irq_mask;
    logic [IRQ_N-1:0] irq_pending;
    logic             nmi_src;
    logic             slow_sel;
    logic [7:0]       mem_din;
    logic             cpu_m1_n;
    logic             cpu_mreq_n;
    logic             cpu_iorq_n;
    logic             cpu_rd_n;
    logic             cpu_int_n;
    logic             cpu_nmi_n;
    logic             cpu_wait_n;
    logic [7:0]       cpu_di;

    // No valid/ready pairs here: the core strobes (m1/mreq/iorq/rd) are level signals
    // sampled every clk_sys, and interrupt acknowledge is the rising edge of m1 & iorq low.
    modport slave (
        input  irq_src, irq_mask, nmi_src, slow_sel, mem_din,
               cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n,
        output cen, irq_pending, cpu_int_n, cpu_nmi_n, cpu_wait_n, cpu_di
    );
    modport master (
        output irq_src, irq_mask, nmi_src, slow_sel, mem_din,
               cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n,
        input  cen, irq_pending, cpu_int_n, cpu_nmi_n, cpu_wait_n, cpu_di
    );
endinterface

// File: rtl/scpu_bus_ctrl.sv
// Z80 bus glue: CPU clock enable, prioritised IRQ controller, NMI pulse, wait states, read latch.
// Define SCPU_IRQ_VECTOR_EN for IM2 vectored acknowledge data; otherwise ack returns 8'hFF (RST 38h).
module scpu_bus_ctrl #(
    parameter int         CEN_DIV  = 16,
    parameter int         IRQ_N    = 4,
    parameter logic [7:0] VEC_BASE = 8'h00,
    parameter int         NMI_LEN  = 4,
    parameter int         WAIT_CYC = 2
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    scpu_bus_ctrl_if.slave bus,
    output logic           wait_dbg
);
    localparam int CW = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;
    localparam int NW = $clog2(NMI_LEN + 1);
    localparam int WW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

    typedef enum logic {W_IDLE, W_HOLD} wait_state_e;

    logic [CW-1:0]    cen_cnt;
    logic             cen_q;
    logic [IRQ_N-1:0] irq_prev, pending_q, irq_rise, ack_clr;
    logic             ack, ack_prev, ack_rise, found, int_n_q;
    logic [7:0]       ack_data, di_q;
    logic             nmi_prev, nmi_rise, nmi_n_q;
    logic [NW-1:0]    nmi_cnt, nmi_cnt_nx;
    wait_state_e      w_state, w_state_nx;
    logic [WW-1:0]    w_cnt, w_cnt_nx;
    logic             as_n, as_prev, acc_start, wait_n_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cen_cnt <= '0;
            cen_q   <= 1'b0;
        end else if (cen_cnt == CW'(CEN_DIV - 1)) begin
            cen_cnt <= '0;
            cen_q   <= 1'b1;
        end else begin
            cen_cnt <= cen_cnt + 1'b1;
            cen_q   <= 1'b0;
        end
    end

    assign ack      = ~bus.cpu_m1_n & ~bus.cpu_iorq_n;
    assign ack_rise = ack & ~ack_prev;
    assign irq_rise = bus.irq_src & ~irq_prev;

    // Lowest pending index wins; only that bit is cleared, and only on the first ack clock.
    always_comb begin
        ack_clr = '0;
        found   = 1'b0;
        for (int i = 0; i < IRQ_N; i++) begin
            if (pending_q[i] && !found) begin
                found      = 1'b1;
                ack_clr[i] = ack_rise;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            irq_prev  <= '0;
            pending_q <= '0;
            ack_prev  <= 1'b0;
            int_n_q   <= 1'b1;
        end else begin
            irq_prev  <= bus.irq_src;
            ack_prev  <= ack;
            // OR-ing the new edge after the ack clear lets a same-clock request survive.
            pending_q <= ((pending_q & ~ack_clr) | irq_rise) & bus.irq_mask;
            int_n_q   <= ~|pending_q;
        end
    end

`ifdef SCPU_IRQ_VECTOR_EN
    logic [2:0] idx_now, idx_q, idx_sel;

    always_comb begin
        idx_now = 3'd0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (pending_q[i]) idx_now = 3'(i);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)      idx_q <= 3'd0;
        else if (ack_rise) idx_q <= idx_now;
    end

    assign idx_sel  = ack_rise ? idx_now : idx_q;
    assign ack_data = VEC_BASE | {4'b0000, idx_sel, 1'b0};
`else
    // All-ones whatever the base: the RST 38h opcode for IM0/IM1 cores.
    assign ack_data = 8'hFF | VEC_BASE;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)           di_q <= 8'hFF;
        else if (ack)           di_q <= ack_data;
        else if (!bus.cpu_rd_n) di_q <= bus.mem_din;
    end

    assign nmi_rise = bus.nmi_src & ~nmi_prev;

    always_comb begin
        nmi_cnt_nx = nmi_cnt;
        if (nmi_rise)                      nmi_cnt_nx = NW'(NMI_LEN);
        else if (cen_q && nmi_cnt != '0)   nmi_cnt_nx = nmi_cnt - 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            nmi_prev <= 1'b0;
            nmi_cnt  <= '0;
            nmi_n_q  <= 1'b1;
        end else begin
            nmi_prev <= bus.nmi_src;
            nmi_cnt  <= nmi_cnt_nx;
            nmi_n_q  <= (nmi_cnt_nx == '0);
        end
    end

    // Access start is the falling edge of "no strobe"; acknowledge cycles are excluded.
    assign as_n      = bus.cpu_mreq_n & bus.cpu_iorq_n;
    assign acc_start = as_prev & ~as_n & bus.slow_sel & ~ack & (WAIT_CYC > 0);

    always_comb begin
        w_state_nx = w_state;
        w_cnt_nx   = w_cnt;
        case (w_state)
            W_IDLE: begin
                if (acc_start) begin
                    w_state_nx = W_HOLD;
                    w_cnt_nx   = WW'(WAIT_CYC);
                end
            end
            W_HOLD: begin
                if (cen_q) begin
                    if (w_cnt <= WW'(1)) begin
                        w_state_nx = W_IDLE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = w_cnt - 1'b1;
                    end
                end
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            w_state  <= W_IDLE;
            w_cnt    <= '0;
            as_prev  <= 1'b0;
            wait_n_q <= 1'b1;
        end else begin
            w_state  <= w_state_nx;
            w_cnt    <= w_cnt_nx;
            as_prev  <= as_n;
            wait_n_q <= (w_state_nx == W_IDLE);
        end
    end

    assign bus.cen         = cen_q;
    assign bus.irq_pending = pending_q;
    assign bus.cpu_int_n   = int_n_q;
    assign bus.cpu_nmi_n   = nmi_n_q;
    assign bus.cpu_wait_n  = wait_n_q;
    assign bus.cpu_di      = di_q;
    assign wait_dbg        = (w_state == W_HOLD);
endmodule

// File: tb/tb_scpu_bus_ctrl.sv
// Self-checking bench for scpu_bus_ctrl: cen timing, IRQ priority/ack, NMI length, wait states, read latch.
module tb_scpu_bus_ctrl;
  localparam logic [7:0] VEC_BASE = 8'h00;
`ifdef SCPU_IRQ_VECTOR_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset_n;
  logic wait_dbg;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  scpu_bus_ctrl_if #(.IRQ_N(4)) bus ();

  scpu_bus_ctrl #(
    .CEN_DIV(16), .IRQ_N(4), .VEC_BASE(VEC_BASE), .NMI_LEN(4), .WAIT_CYC(2)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus),
    .wait_dbg(wait_dbg)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [7:0] ack_model(input int idx);
    return VEC_EN ? (VEC_BASE | 8'(idx << 1)) : 8'hFF;
  endfunction

  task automatic sb_pop(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.cpu_di, e);
    end
  endtask

  // Drive one acknowledge clock, expecting vector for pending index idx.
  task automatic ack_cycle(input string tag, input int idx);
    bus.cpu_m1_n   = 1'b0;
    bus.cpu_iorq_n = 1'b0;
    exp_q.push_back(ack_model(idx));
    tick();
    sb_pop(tag);
    bus.cpu_m1_n   = 1'b1;
    bus.cpu_iorq_n = 1'b1;
  endtask

  initial begin
    int pulses, n, step;
    bit restarted, seen_low;
    logic [7:0] d;

    reset_n        = 1'b0;
    bus.irq_src    = '0;
    bus.irq_mask   = '0;
    bus.nmi_src    = 1'b0;
    bus.slow_sel   = 1'b0;
    bus.mem_din    = 8'h00;
    bus.cpu_m1_n   = 1'b1;
    bus.cpu_mreq_n = 1'b1;
    bus.cpu_iorq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    repeat (3) tick();
    check("rst_cen", bus.cen, 0);
    check("rst_pending", bus.irq_pending, 0);
    check("rst_int_n", bus.cpu_int_n, 1);
    check("rst_nmi_n", bus.cpu_nmi_n, 1);
    check("rst_wait_n", bus.cpu_wait_n, 1);
    check("rst_di", bus.cpu_di, 8'hFF);
    reset_n = 1'b1;

    // cen: high on clk 16, 32, 48, 64 after release, one clock wide
    for (int k = 1; k <= 64; k++) begin
      tick();
      check($sformatf("cen_clk%0d", k), bus.cen, (k % 16 == 0));
    end

    // Two same-clock requests, serviced by priority
    bus.irq_mask = 4'b1111;
    bus.irq_src  = 4'b0110;
    tick();
    check("t2_pending", bus.irq_pending, 4'b0110);
    check("t2_int_lat", bus.cpu_int_n, 1);
    tick();
    check("t2_int_low", bus.cpu_int_n, 0);
    ack_cycle("t2_ack1_di", 1);
    check("t2_pend_after1", bus.irq_pending, 4'b0100);
    tick();
    ack_cycle("t2_ack2_di", 2);
    check("t2_pend_after2", bus.irq_pending, 4'b0000);
    tick();
    check("t2_int_high", bus.cpu_int_n, 1);

    // Masked edge dropped; unmasking removal clears pending
    bus.irq_src = 4'b0000;
    tick();
    bus.irq_mask = 4'b0111;
    bus.irq_src  = 4'b1000;
    tick();
    check("t3_masked", bus.irq_pending, 4'b0000);
    bus.irq_src = 4'b0010;
    tick();
    check("t3_set1", bus.irq_pending, 4'b0010);
    bus.irq_mask = 4'b0101;
    tick();
    check("t3_mask_clr", bus.irq_pending, 4'b0000);
    tick();
    check("t3_int_high", bus.cpu_int_n, 1);

    // New edge on the bit being acknowledged wins over its clear
    bus.irq_mask = 4'b1111;
    bus.irq_src  = 4'b0000;
    tick();
    bus.irq_src = 4'b0001;
    tick();
    check("t4_set0", bus.irq_pending, 4'b0001);
    bus.irq_src = 4'b0000;
    tick();
    bus.irq_src = 4'b0001;
    ack_cycle("t4_ack_di", 0);
    check("t4_pend_kept", bus.irq_pending, 4'b0001);
    tick();
    check("t4_int_kept", bus.cpu_int_n, 0);
    bus.irq_mask = 4'b0000;
    tick();
    bus.irq_mask = 4'b1111;
    bus.irq_src  = 4'b0000;
    tick();
    tick();
    check("t4_cleared", bus.irq_pending, 4'b0000);
    check("t4_int_high", bus.cpu_int_n, 1);

    // Read latch, hold, and ack precedence over memory data
    for (int k = 0; k < 4; k++) begin
      bus.cpu_rd_n = 1'b0;
      bus.mem_din  = 8'($urandom_range(0, 255));
      exp_q.push_back(bus.mem_din);
      tick();
      sb_pop($sformatf("rd_di%0d", k));
    end
    d = bus.mem_din;
    bus.cpu_rd_n = 1'b1;
    bus.mem_din  = ~d;
    exp_q.push_back(d);
    tick();
    sb_pop("di_hold");
    bus.cpu_rd_n = 1'b0;
    bus.mem_din  = 8'h5A;
    ack_cycle("ack_over_rd", 0);
    bus.cpu_rd_n = 1'b1;
    tick();

    // NMI: four cen pulses low
    bus.nmi_src = 1'b1;
    tick();
    bus.nmi_src = 1'b0;
    check("nmi_low_start", bus.cpu_nmi_n, 0);
    pulses = 0;
    n = 0;
    while (bus.cpu_nmi_n == 1'b0 && n < 400) begin
      if (bus.cen) pulses++;
      tick();
      n++;
    end
    check("nmi_timeout1", (n < 400), 1);
    check("nmi_pulses", pulses, 4);

    // NMI retriggered at the second pulse: six pulses total
    tick();
    bus.nmi_src = 1'b1;
    tick();
    pulses = 0;
    n = 0;
    restarted = 1'b0;
    while (bus.cpu_nmi_n == 1'b0 && n < 400) begin
      bus.nmi_src = 1'b0;
      if (bus.cen) begin
        pulses++;
        if (pulses == 2 && !restarted) begin
          bus.nmi_src = 1'b1;
          restarted   = 1'b1;
        end
      end
      tick();
      n++;
    end
    bus.nmi_src = 1'b0;
    check("nmi_timeout2", (n < 400), 1);
    check("nmi_retrig_pulses", pulses, 6);

    // Slow access: wait low one clock later, two cen pulses; a second start mid-wait is ignored
    bus.slow_sel   = 1'b1;
    bus.cpu_mreq_n = 1'b0;
    tick();
    check("wait_low", bus.cpu_wait_n, 0);
    check("wait_dbg", wait_dbg, 1);
    pulses = 0;
    n = 0;
    step = 0;
    while (bus.cpu_wait_n == 1'b0 && n < 400) begin
      if (step == 1) begin
        bus.cpu_mreq_n = 1'b0;
        step = 2;
      end
      if (bus.cen) begin
        pulses++;
        if (pulses == 1 && step == 0) begin
          bus.cpu_mreq_n = 1'b1;
          step = 1;
        end
      end
      tick();
      n++;
    end
    check("wait_timeout", (n < 400), 1);
    check("wait_pulses", pulses, 2);
    bus.cpu_mreq_n = 1'b1;
    tick();

    // Reset mid-wait releases immediately
    bus.cpu_mreq_n = 1'b0;
    repeat (3) tick();
    check("wait_before_rst", bus.cpu_wait_n, 0);
    reset_n = 1'b0;
    #1;
    check("wait_async_rst", bus.cpu_wait_n, 1);
    check("di_async_rst", bus.cpu_di, 8'hFF);
    bus.cpu_mreq_n = 1'b1;
    bus.slow_sel   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Fast access never waits
    bus.cpu_mreq_n = 1'b0;
    seen_low = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.cpu_wait_n == 1'b0) seen_low = 1'b1;
    end
    check("wait_fast_access", seen_low, 0);
    bus.cpu_mreq_n = 1'b1;
    tick();

    // Acknowledge with slow_sel high and nothing pending: no wait, vector for index 0
    bus.slow_sel   = 1'b1;
    bus.cpu_m1_n   = 1'b0;
    bus.cpu_iorq_n = 1'b0;
    exp_q.push_back(ack_model(0));
    tick();
    sb_pop("ack_nopend_di");
    seen_low = (bus.cpu_wait_n == 1'b0);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.cpu_wait_n == 1'b0) seen_low = 1'b1;
    end
    check("wait_on_ack", seen_low, 0);
    check("ack_nopend_pending", bus.irq_pending, 0);
    bus.cpu_m1_n   = 1'b1;
    bus.cpu_iorq_n = 1'b1;
    bus.slow_sel   = 1'b0;
    tick();

    if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
